// File: rtl/bocks_video_pkg.sv
// Shared definitions for the Bocks video path.
//  - Default 640x480@60 timing constants and the derived line/frame totals.
//  - coord_t: 12-bit unsigned raster coordinate.
//  - vid_sync_t: the bundle of sync/blank strobes that travels through the
//    pixel-pipeline delay line.
//  - vid_sync_idle(): the inactive value of that bundle for a given sync
//    polarity. It is used both as the reset value and as the fill value of
//    the delay stages.
package bocks_video_pkg;

  localparam int DFLT_H_ACTIVE = 640;
  localparam int DFLT_H_FP     = 16;
  localparam int DFLT_H_SYNC   = 96;
  localparam int DFLT_H_BP     = 48;
  localparam int DFLT_V_ACTIVE = 480;
  localparam int DFLT_V_FP     = 10;
  localparam int DFLT_V_SYNC   = 2;
  localparam int DFLT_V_BP     = 33;

  localparam int H_TOTAL = DFLT_H_ACTIVE + DFLT_H_FP + DFLT_H_SYNC + DFLT_H_BP;
  localparam int V_TOTAL = DFLT_V_ACTIVE + DFLT_V_FP + DFLT_V_SYNC + DFLT_V_BP;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic hblank;
    logic vblank;
  } vid_sync_t;

  // Both syncs are deasserted, display is disabled and the raster counts
  // as blanked in both directions.
  function automatic vid_sync_t vid_sync_idle(input logic hs_pol, input logic vs_pol);
    vid_sync_t s;
    s.hs     = ~hs_pol;
    s.vs     = ~vs_pol;
    s.de     = 1'b0;
    s.hblank = 1'b1;
    s.vblank = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/bocks_sync_delay.sv
// Clock-enable gated shift register with an asynchronous clear to a
// configurable idle pattern.
// Ports:
//  clk_i   in   1      clock, rising edge
//  rst_ni  in   1      asynchronous active-low clear; every stage loads IDLE
//  ce_i    in   1      advance enable; 0 holds every stage
//  d_i     in   WIDTH  value entering the line
//  q_o     out  WIDTH  value leaving the line, DEPTH ce-cycles after d_i
// DEPTH = 0 is a straight wire, so callers can parameterise the delay away.
module bocks_sync_delay #(
  parameter int               DEPTH = 2,
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/bocks_vga_timing.sv
// Raster timing generator for the Bocks video path (640x480@60 by default).
// A free-running horizontal/vertical counter pair is registered into pixel
// coordinates and frame markers for the pixel generator. The same counter
// state also produces the sync/DE/blank strobes. These strobes are delayed
// PIPE_DLY ce-cycles so they arrive together with the pixel-pipeline output.
// Ports:
//  pclk         in   1   pixel clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  ce           in   1   pixel enable; 0 freezes every register
//  x, y         out  12  current column / line (registered counter value)
//  active       out  1   x/y inside the visible area
//  line_start   out  1   x==0, aligned with x/y
//  frame_start  out  1   x==0 && y==0, aligned with x/y
//  hs, vs       out  1   sync outputs at HS_POL/VS_POL when asserted, delayed
//  de           out  1   active, delayed
//  hblank       out  1   x>=H_ACTIVE, delayed
//  vblank       out  1   y>=V_ACTIVE, delayed
module bocks_vga_timing
  import bocks_video_pkg::*;
#(
  parameter int H_ACTIVE = DFLT_H_ACTIVE,
  parameter int H_FP     = DFLT_H_FP,
  parameter int H_SYNC   = DFLT_H_SYNC,
  parameter int H_BP     = DFLT_H_BP,
  parameter int V_ACTIVE = DFLT_V_ACTIVE,
  parameter int V_FP     = DFLT_V_FP,
  parameter int V_SYNC   = DFLT_V_SYNC,
  parameter int V_BP     = DFLT_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        ce,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        hblank,
  output logic        vblank
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam vid_sync_t SYNC_IDLE = vid_sync_idle(HS_POL, VS_POL);

  // Reject geometries that the 12-bit counters or the delay line cannot hold.
  if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
    $error("bocks_vga_timing: PIPE_DLY must be in 0..8");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("bocks_vga_timing: porch and sync widths must be non-zero");
  end
  if (H_TOT > COORD_MAX || V_TOT > COORD_MAX) begin : g_bad_total
    $error("bocks_vga_timing: H/V total exceeds 12-bit counter range");
  end

  coord_t    h_q, h_d;
  coord_t    v_q, v_d;
  coord_t    x_q, y_q;
  logic      active_q, active_d;
  logic      line_start_q, line_start_d;
  logic      frame_start_q, frame_start_d;
  vid_sync_t sync_q, sync_d;
  vid_sync_t sync_dly;

  // Counter advance. v only moves on the h wrap, so it is constant across a line.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : coord_t'(v_q + coord_t'(1));
    end else begin
      h_d = coord_t'(h_q + coord_t'(1));
    end
  end

  // Everything below is decoded from the counter value about to be
  // registered. As a result x/y, the markers and the undelayed sync bundle
  // all describe the same pixel.
  always_comb begin
    active_d      = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);

    sync_d        = SYNC_IDLE;
    sync_d.hs     = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    // vs decodes v alone, so its edges land on the first pixel of a line.
    sync_d.vs     = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    sync_d.de     = active_d;
    sync_d.hblank = (h_q >= H_ACT_C);
    sync_d.vblank = (v_q >= V_ACT_C);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_q        <= SYNC_IDLE;
    end else if (ce) begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= h_q;
      y_q           <= v_q;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  // sync_q is already aligned with x/y. The delay line therefore adds
  // exactly PIPE_DLY ce-cycles on top of that alignment.
  bocks_sync_delay #(
    .DEPTH (PIPE_DLY),
    .WIDTH ($bits(vid_sync_t)),
    .IDLE  (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i  (pclk),
    .rst_ni (rst_n),
    .ce_i   (ce),
    .d_i    (sync_q),
    .q_o    (sync_dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hs          = sync_dly.hs;
  assign vs          = sync_dly.vs;
  assign de          = sync_dly.de;
  assign hblank      = sync_dly.hblank;
  assign vblank      = sync_dly.vblank;

endmodule
